voice_path: RTL and testbench
=============================

VOICE_PATH -- requirements
Module: voice_path

Interface
REQ-001 Parameter DIV_W, default 19, width of divisor and oscillator count.
REQ-002 Parameter SAMPLE_W, default 8, width of quotient and output sample.
REQ-003 Parameter VOL_W, default 4, width of volume control.
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port n_rst  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  voice enable; low holds the oscillator and aborts conversion.
REQ-007 Port sample_now  input  1  one-cycle conversion request from the sample-rate divider.
REQ-008 Port mode  input  2  0 off, 1 square, 2 saw, 3 triangle.
REQ-009 Port divisor  input  DIV_W  oscillator period in clk cycles.
REQ-010 Port volume  input  VOL_W  output amplitude; 0 mutes.
REQ-011 Port sample  output  SAMPLE_W  shaped, scaled sample; registered.
REQ-012 Port done  output  1  one-cycle pulse when sample has just updated.
REQ-013 Port busy  output  1  high while a conversion is in progress.

Function
REQ-014 Oscillator count SHALL increment by 1 each cycle while enable=1 and wrap to 0 on the cycle after count >= divisor-1.
REQ-015 When divisor is 0 or 1, count SHALL hold at 0; when enable=0, count SHALL be cleared to 0 and held.
REQ-016 A divisor reduction below the current count SHALL cause a wrap to 0 on the next edge, with no out-of-range counting.
REQ-017 The FSM SHALL have states IDLE, DIVIDE, SHAPE; busy SHALL be 1 in DIVIDE and SHAPE only.
REQ-018 In IDLE with enable=1 and sample_now=1, the block SHALL latch count, divisor, mode and volume, then enter DIVIDE.
REQ-019 sample_now SHALL be ignored while busy=1 or enable=0; there is no queueing.
REQ-020 DIVIDE SHALL compute Q = floor(count*2^SAMPLE_W / divisor) by restoring division, one quotient bit per cycle, for exactly SAMPLE_W cycles.
REQ-021 Q SHALL saturate to 2^SAMPLE_W-1 if latched count >= latched divisor; Q SHALL be 0 if latched divisor is 0.
REQ-022 SHAPE SHALL last 1 cycle; on its exit edge, sample SHALL update, done SHALL pulse high for 1 cycle, and the FSM SHALL return to IDLE.
REQ-023 Latency: done SHALL be high in the cycle SAMPLE_W+2 edges after the edge that captured sample_now.
REQ-024 With MAX=2^SAMPLE_W-1 and HALF=2^(SAMPLE_W-1), shaped value: off 0; square MAX if Q<HALF, else 0; saw Q; triangle 2Q if Q<HALF, else 2*(MAX-Q)+1.
REQ-025 sample SHALL equal (shaped*(volume+1))>>VOL_W when volume != 0, and 0 when volume=0; at volume 2^VOL_W-1, it SHALL equal shaped exactly.
REQ-026 Inputs changed during a conversion SHALL NOT affect that conversion; only latched values are used.
REQ-027 enable falling in DIVIDE or SHAPE SHALL return the FSM to IDLE on the next edge, with no done pulse and sample unchanged.
REQ-028 sample SHALL hold its value between done pulses.

Reset
REQ-029 Asserting n_rst low SHALL immediately force count=0, FSM=IDLE, sample=0, done=0 and busy=0, including mid-conversion.
REQ-030 After n_rst deasserts, the first conversion SHALL require a fresh sample_now.

Structure
REQ-031 Package voice_pkg SHALL hold the mode encoding enum (OFF, SQUARE, SAW, TRIANGLE) and the FSM state enum.
REQ-032 The restoring divider SHALL be one sub-module, voice_div, with start/done handshake and parameters DIV_W and SAMPLE_W; the oscillator, shaper and volume scaler SHALL be in voice_path.

Verification
REQ-033 Saw: divisor=8, volume=15, sample_now when count=4 -> done 10 cycles later, sample=128.
REQ-034 Square/triangle: same capture with count=4 -> square 0, triangle 255; with count=2 (Q=64) -> square 255, triangle 128.
REQ-035 Volume: saw with Q=128, volume=7 -> sample=64; volume=0 -> sample=0, done still pulses.
REQ-036 Busy collision: second sample_now 3 cycles after the first -> ignored; exactly one done pulse; busy high for 9 cycles.
REQ-037 Abort: enable low in 5th DIVIDE cycle -> no done, sample unchanged, count=0; n_rst low mid-DIVIDE -> all outputs 0 at once.
REQ-038 Divisor shrink: count=100, divisor changed 200->50 -> count=0 on next edge; a capture on the shrink cycle gives sample=MAX (saw, saturated).

Source files
------------

// File: rtl/voice_pkg.sv
// Shared types for the voice path: waveform mode encoding and conversion FSM states.
package voice_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    SHAPE  = 2'd2
  } state_e;

endpackage

// File: rtl/voice_div.sv
// Restoring divider producing floor(dividend*2^SAMPLE_W / divisor), one quotient bit per cycle.
// The first bit is resolved on the start edge, so done_o pulses in the SAMPLE_W-th busy cycle.
module voice_div #(
  parameter int DIV_W    = 19,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DIV_W-1:0]    dividend_i,
  input  logic [DIV_W-1:0]    divisor_i,
  output logic [SAMPLE_W-1:0] quotient_o,
  output logic                done_o
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic [DIV_W-1:0]    rem_q, rem_d;
  logic [DIV_W-1:0]    dvs_q, dvs_d;
  logic [SAMPLE_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                sat_q, sat_d;
  logic [DIV_W:0]      step_s;

  // One restoring step: returns {quotient bit, new remainder}.
  function automatic logic [DIV_W:0] div_step(input logic [DIV_W-1:0] rem,
                                              input logic [DIV_W-1:0] dvs);
    logic [DIV_W:0] shifted;
    logic [DIV_W:0] trial;
    shifted = {rem, 1'b0};
    trial   = shifted - {1'b0, dvs};
    if (shifted >= {1'b0, dvs}) begin
      div_step = {1'b1, DIV_W'(trial)};
    end else begin
      div_step = {1'b0, DIV_W'(shifted)};
    end
  endfunction

  // Next-state logic: load and first step on start, then one step per cycle.
  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    left_d = left_q;
    zero_d = zero_q;
    sat_d  = sat_q;
    done_d = 1'b0;
    if (start_i) begin
      step_s = div_step(dividend_i, divisor_i);
    end else begin
      step_s = div_step(rem_q, dvs_q);
    end
    if (abort_i) begin
      left_d = '0;
    end else if (start_i) begin
      rem_d  = DIV_W'(step_s);
      dvs_d  = divisor_i;
      quo_d  = {{(SAMPLE_W-1){1'b0}}, step_s[DIV_W]};
      zero_d = (divisor_i == '0);
      sat_d  = (dividend_i >= divisor_i);
      left_d = CNT_W'(SAMPLE_W - 1);
      done_d = (SAMPLE_W == 1);
    end else if (left_q != '0) begin
      rem_d  = DIV_W'(step_s);
      quo_d  = {quo_q[SAMPLE_W-2:0], step_s[DIV_W]};
      left_d = left_q - CNT_W'(1);
      done_d = (left_q == CNT_W'(1));
    end else begin
      left_d = '0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      left_q <= '0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      left_q <= left_d;
      done_q <= done_d;
      zero_q <= zero_d;
      sat_q  <= sat_d;
    end
  end

  assign quotient_o = zero_q ? '0 : (sat_q ? '1 : quo_q);
  assign done_o     = done_q;

endmodule

// File: rtl/voice_path.sv
// One synthesiser voice: free-running oscillator, sampled on request, divided to a
// phase fraction, shaped into a waveform and scaled by volume.
module voice_path
  import voice_pkg::*;
#(
  parameter int DIV_W    = 19,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable,
  input  logic                sample_now,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    divisor,
  input  logic [VOL_W-1:0]    volume,
  output logic [SAMPLE_W-1:0] sample,
  output logic                done,
  output logic                busy
);

  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    count_q, count_d;
  mode_e               mode_q, mode_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                start_s, abort_s, fire_s, div_done_s;
  logic [SAMPLE_W-1:0] div_quot_s;

  function automatic logic [SAMPLE_W-1:0] shape_wave(input mode_e m,
                                                     input logic [SAMPLE_W-1:0] q);
    logic [SAMPLE_W-1:0] inv;
    inv = ~q;
    case (m)
      OFF:      shape_wave = '0;
      SQUARE:   shape_wave = q[SAMPLE_W-1] ? '0 : '1;
      SAW:      shape_wave = q;
      TRIANGLE: shape_wave = q[SAMPLE_W-1] ? SAMPLE_W'({inv, 1'b1}) : SAMPLE_W'({q, 1'b0});
      default:  shape_wave = '0;
    endcase
  endfunction

  // Full volume multiplies by 2^VOL_W, so the top code passes the sample through unchanged.
  function automatic logic [SAMPLE_W-1:0] scale_vol(input logic [SAMPLE_W-1:0] shaped,
                                                    input logic [VOL_W-1:0] vol);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(shaped) * (PROD_W'(vol) + PROD_W'(1));
    if (vol == '0) begin
      scale_vol = '0;
    end else begin
      scale_vol = SAMPLE_W'(prod >> VOL_W);
    end
  endfunction

  // Oscillator next count; a shrunken divisor wraps immediately.
  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (divisor <= DIV_W'(1)) begin
      count_d = '0;
    end else if (count_q >= divisor - DIV_W'(1)) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (enable && sample_now) ? DIVIDE : IDLE;
      DIVIDE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (div_done_s) begin
          state_d = SHAPE;
        end else begin
          state_d = DIVIDE;
        end
      end
      SHAPE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: divider start/abort and the sample-update strobe.
  always_comb begin
    start_s = 1'b0;
    abort_s = 1'b0;
    fire_s  = 1'b0;
    case (state_q)
      IDLE:    start_s = enable & sample_now;
      DIVIDE:  abort_s = ~enable;
      SHAPE: begin
        abort_s = ~enable;
        fire_s  = enable;
      end
      default: abort_s = 1'b1;
    endcase
  end

  voice_div #(
    .DIV_W    (DIV_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_div (
    .clk        (clk),
    .n_rst      (n_rst),
    .start_i    (start_s),
    .abort_i    (abort_s),
    .dividend_i (count_q),
    .divisor_i  (divisor),
    .quotient_o (div_quot_s),
    .done_o     (div_done_s)
  );

  // Conversion parameters are frozen at capture; sample only moves on a completed conversion.
  always_comb begin
    mode_d = mode_q;
    vol_d  = vol_q;
    if (start_s) begin
      mode_d = mode_e'(mode);
      vol_d  = volume;
    end else begin
      mode_d = mode_q;
    end
    if (fire_s) begin
      sample_d = scale_vol(shape_wave(mode_q, div_quot_s), vol_q);
    end else begin
      sample_d = sample_q;
    end
    done_d = fire_s;
    busy_d = (state_d != IDLE);
  end

  // Oscillator and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q  <= '0;
      mode_q   <= OFF;
      vol_q    <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      mode_q   <= mode_d;
      vol_q    <= vol_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign sample = sample_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_voice_path.sv
// Self-checking bench for voice_path: behavioural model checked every cycle, plus
// directed scenarios pinned to hand-computed values, then randomized traffic.
module tb_voice_path;

  localparam int DW   = 19;
  localparam int SW   = 8;
  localparam int VW   = 4;
  localparam int LAT  = SW + 1;
  localparam int MAXV = (1 << SW) - 1;
  localparam int HALF = 1 << (SW - 1);

  logic          clk;
  logic          n_rst;
  logic          enable;
  logic          sample_now;
  logic [1:0]    mode;
  logic [DW-1:0] divisor;
  logic [VW-1:0] volume;
  logic [SW-1:0] sample;
  logic          done;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Behavioural model state
  int m_count  = 0;
  int m_left   = 0;
  int m_res    = 0;
  int m_sample = 0;
  bit m_pend   = 1'b0;
  bit m_done   = 1'b0;

  voice_path #(
    .DIV_W    (DW),
    .SAMPLE_W (SW),
    .VOL_W    (VW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .sample_now (sample_now),
    .mode       (mode),
    .divisor    (divisor),
    .volume     (volume),
    .sample     (sample),
    .done       (done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expect_sample(input int cnt, input int dvs, input int md, input int vol);
    int q;
    int shp;
    if (dvs == 0) q = 0;
    else if (cnt >= dvs) q = MAXV;
    else q = int'((longint'(cnt) * (1 << SW)) / dvs);
    case (md)
      1:       shp = (q < HALF) ? MAXV : 0;
      2:       shp = q;
      3:       shp = (q < HALF) ? 2 * q : 2 * (MAXV - q) + 1;
      default: shp = 0;
    endcase
    return (vol == 0) ? 0 : (shp * (vol + 1)) / (1 << VW);
  endfunction

  // Reference model: a captured conversion completes LAT edges later unless enable drops.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_count  <= 0;
      m_left   <= 0;
      m_res    <= 0;
      m_sample <= 0;
      m_pend   <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_pend) begin
        if (!enable) begin
          m_pend <= 1'b0;
        end else if (m_left == 1) begin
          m_sample <= m_res;
          m_done   <= 1'b1;
          m_pend   <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (enable && sample_now) begin
        m_res  <= expect_sample(m_count, int'(divisor), int'(mode), int'(volume));
        m_pend <= 1'b1;
        m_left <= LAT;
      end
      if (!enable || divisor <= 1 || m_count >= int'(divisor) - 1) m_count <= 0;
      else m_count <= m_count + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("sample", sample, m_sample);
      check("done", done, m_done);
      check("busy", busy, m_pend);
      check("count", dut.count_q, m_count);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (m_count != target && n < 1000) begin
      cyc();
      n++;
    end
    check("wait_count", m_count, target);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    check({name, " latency"}, lat, SW + 2);
  endtask

  task automatic conv(input string name, input logic [1:0] md, input logic [VW-1:0] vol,
                      input int target, input int exp);
    int lat;
    wait_count(target);
    mode       = md;
    volume     = vol;
    sample_now = 1'b1;
    cyc();
    sample_now = 1'b0;
    mode       = ~md;
    volume     = VW'($urandom);
    wait_done(name, lat);
    check({name, " sample"}, sample, exp);
    check({name, " model"}, m_sample, exp);
  endtask

  initial begin
    int n_busy;
    int n_done;
    int lat;
    n_rst      = 1'b1;
    enable     = 1'b0;
    sample_now = 1'b0;
    mode       = 2'd0;
    divisor    = '0;
    volume     = '0;
    #1 n_rst = 1'b0;
    #2;
    check("reset sample", sample, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    chk_on = 1'b1;
    repeat (2) cyc();
    n_rst   = 1'b1;
    enable  = 1'b1;
    divisor = DW'(8);
    cyc();

    conv("saw c4", 2'd2, 4'd15, 4, 128);
    conv("square c4", 2'd1, 4'd15, 4, 0);
    conv("tri c4", 2'd3, 4'd15, 4, 255);
    conv("square c2", 2'd1, 4'd15, 2, 255);
    conv("tri c2", 2'd3, 4'd15, 2, 128);
    conv("saw vol7", 2'd2, 4'd7, 4, 64);
    conv("saw vol0", 2'd2, 4'd0, 4, 0);

    // Second request three cycles into a conversion is dropped.
    wait_count(4);
    mode       = 2'd2;
    volume     = 4'd15;
    sample_now = 1'b1;
    n_busy     = 0;
    n_done     = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (busy) n_busy++;
      if (done) n_done++;
      sample_now = (i == 3);
    end
    check("collision busy cycles", n_busy, 9);
    check("collision done pulses", n_done, 1);
    check("collision sample", sample, 128);

    // Abort in the fifth divide cycle.
    wait_count(2);
    sample_now = 1'b1;
    cyc();
    sample_now = 1'b0;
    repeat (4) cyc();
    enable = 1'b0;
    cyc();
    check("abort busy", busy, 0);
    check("abort count", dut.count_q, 0);
    enable = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done) n_done++;
    end
    check("abort done pulses", n_done, 0);
    check("abort sample held", sample, 128);

    // Asynchronous reset mid-divide, then no conversion without a fresh request.
    wait_count(4);
    sample_now = 1'b1;
    cyc();
    sample_now = 1'b0;
    repeat (2) cyc();
    #2 n_rst = 1'b0;
    #1;
    check("midreset sample", sample, 0);
    check("midreset done", done, 0);
    check("midreset busy", busy, 0);
    check("midreset count", dut.count_q, 0);
    cyc();
    n_rst  = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("post-reset done pulses", n_done, 0);
    check("post-reset busy", n_busy, 0);

    // Divisor shrink below the running count, with a capture on the same cycle.
    divisor = DW'(200);
    wait_count(100);
    divisor    = DW'(50);
    mode       = 2'd2;
    volume     = 4'd15;
    sample_now = 1'b1;
    cyc();
    sample_now = 1'b0;
    check("shrink count", dut.count_q, 0);
    wait_done("shrink", lat);
    check("shrink sample", sample, MAXV);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      enable     = ($urandom_range(0, 24) != 0);
      sample_now = ($urandom_range(0, 3) == 0);
      mode       = 2'($urandom);
      volume     = VW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0:       divisor = DW'(0);
          1:       divisor = DW'(1);
          2:       divisor = DW'($urandom_range(2, 5));
          3:       divisor = DW'($urandom_range(2, 40));
          4:       divisor = DW'($urandom_range(40, 400));
          default: divisor = DW'($urandom);
        endcase
      end
      cyc();
    end
    enable     = 1'b0;
    sample_now = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
